// File: rtl/kpg_pkg.sv
// Shared KPG code definitions for the classifier and the carry pipeline.
// Codes are ASCII bytes, one per operand bit.
package kpg_pkg;

  localparam int KPG_W = 8;

  typedef logic [KPG_W-1:0] kpg_t;

  localparam kpg_t KPG_K = 8'h6B;
  localparam kpg_t KPG_P = 8'h70;
  localparam kpg_t KPG_G = 8'h67;

  function automatic logic is_legal_kpg(input kpg_t code);
    return (code == KPG_K) || (code == KPG_P) || (code == KPG_G);
  endfunction

endpackage

// File: rtl/kpg_carry_pipe_if.sv
// Handshake bundle for kpg_carry_pipe: code/carry-in request side and sum/carry-out response side.
// KPG_CARRY_PIPE_ERR_CHECK_EN adds the code_err response bit.
interface kpg_carry_pipe_if #(
  parameter int NBITS = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NBITS*8-1:0] kpg_in;
  logic               cin;
  logic               out_valid;
  logic               out_ready;
  logic [NBITS-1:0]   sum;
  logic               cout;
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
  logic               code_err;

  modport master (
    output in_valid, kpg_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout, code_err
  );
  modport slave (
    input  in_valid, kpg_in, cin, out_ready,
    output in_ready, out_valid, sum, cout, code_err
  );
`else
  modport master (
    output in_valid, kpg_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, kpg_in, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/kpg_slice_resolve.sv
// Combinational ripple through one SLICE-bit slice of KPG codes.
// Illegal codes behave as kill and raise err_o.
module kpg_slice_resolve
  import kpg_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE*KPG_W-1:0] codes_i,
  input  logic                   cin_i,
  output logic [SLICE-1:0]       sum_o,
  output logic                   cout_o,
  output logic                   err_o
);

  always_comb begin
    logic c;
    kpg_t code;
    // NOTE: blocking assignments are deliberate here; c must ripple bit by bit within one evaluation.
    c     = cin_i;
    code  = KPG_K;
    sum_o = '0;
    err_o = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      code     = codes_i[i*KPG_W +: KPG_W];
      sum_o[i] = (code == KPG_P) ^ c;
      if (code == KPG_G)      c = 1'b1;
      else if (code != KPG_P) c = 1'b0;
      err_o = err_o | ~is_legal_kpg(code);
    end
    cout_o = c;
  end

endmodule

// File: rtl/kpg_carry_pipe.sv
// Pipelined KPG carry resolver: one SLICE-bit slice per stage, NBITS a multiple of SLICE.
// Optional macro KPG_CARRY_PIPE_ERR_CHECK_EN tracks illegal codes per operation onto bus.code_err.
module kpg_carry_pipe
  import kpg_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int SLICE = 8
) (
  input logic             clk,
  input logic             rst_n,
  kpg_carry_pipe_if.slave bus
);

  localparam int STAGES  = NBITS / SLICE;
  localparam int SLICE_W = SLICE * KPG_W;

  logic stall;

  // Block s resolves slice s and registers the result; slice 0 resolves directly off the inputs,
  // so the last block's registers are the outputs and latency is exactly STAGES cycles.
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int CW = (STAGES - s) * SLICE_W;

    logic [CW-1:0]          codes;
    logic                   carry;
    logic                   valid;
    logic [SLICE-1:0]       sl_sum;
    logic                   sl_cout;
    logic [(s+1)*SLICE-1:0] sum_d;
    logic [(s+1)*SLICE-1:0] sum_q;
    logic                   valid_q;
    logic                   carry_q;
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
    logic                   sl_err;
    logic                   err_in;
    logic                   err_q;
`endif

    if (s == 0) begin : g_src
      assign codes = bus.kpg_in;
      assign carry = bus.cin;
      assign valid = bus.in_valid;
      assign sum_d = sl_sum;
    end else begin : g_src
      assign codes = g_st[s-1].g_fwd.codes_q;
      assign carry = g_st[s-1].carry_q;
      assign valid = g_st[s-1].valid_q;
      assign sum_d = {sl_sum, g_st[s-1].sum_q};
    end

    kpg_slice_resolve #(.SLICE(SLICE)) u_slice (
      .codes_i (codes[SLICE_W-1:0]),
      .cin_i   (carry),
      .sum_o   (sl_sum),
      .cout_o  (sl_cout),
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
      .err_o   (sl_err)
`else
      .err_o   ()
`endif
    );

    // NOTE: non-blocking assignments for all state so every stage samples the pre-edge values.
    // NOTE: data registers are reset as well, so sum/cout read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= valid;
        carry_q <= sl_cout;
        sum_q   <= sum_d;
      end
    end

    // Codes of already-resolved slices are dropped, so this register shrinks stage by stage.
    if (s < STAGES - 1) begin : g_fwd
      logic [CW-SLICE_W-1:0] codes_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      codes_q <= '0;
        else if (!stall) codes_q <= codes[CW-1:SLICE_W];
      end
    end

`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
    if (s == 0) begin : g_err_src
      assign err_in = 1'b0;
    end else begin : g_err_src
      assign err_in = g_st[s-1].err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (!stall) err_q <= err_in | sl_err;
    end
`endif
  end

  assign stall         = g_st[STAGES-1].valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = g_st[STAGES-1].valid_q;
  assign bus.sum       = g_st[STAGES-1].sum_q;
  assign bus.cout      = g_st[STAGES-1].carry_q;
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
  assign bus.code_err  = g_st[STAGES-1].valid_q && g_st[STAGES-1].err_q;
`endif

endmodule

// File: tb/tb_kpg_carry_pipe.sv
// Directed and randomized bench for kpg_carry_pipe with an in-order scoreboard of a+b+cin results.
module tb_kpg_carry_pipe;
  import kpg_pkg::*;

  localparam int NBITS = 32;

  typedef struct {
    logic [NBITS-1:0] sum;
    logic             cout;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  kpg_carry_pipe_if #(.NBITS(NBITS)) bus ();

  kpg_carry_pipe #(.NBITS(NBITS), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  logic acc      = 1'b0;
  exp_t drv;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NBITS*8-1:0] to_kpg(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    logic [NBITS*8-1:0] v;
    v = '0;
    for (int i = 0; i < NBITS; i++)
      v[i*8 +: 8] = (a[i] & b[i]) ? KPG_G : ((a[i] ^ b[i]) ? KPG_P : KPG_K);
    return v;
  endfunction

  task automatic set_op(input logic [NBITS*8-1:0] k, input logic c,
                        input logic [NBITS-1:0] es, input logic ec, input logic ee);
    bus.in_valid = 1'b1;
    bus.kpg_in   = k;
    bus.cin      = c;
    drv.sum      = es;
    drv.cout     = ec;
    drv.err      = ee;
  endtask

  // Settle, account for this cycle's handshakes, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(drv);
    if (bus.out_valid && bus.out_ready) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sum", 64'(bus.sum), 64'(e.sum));
        check("cout", 64'(bus.cout), 64'(e.cout));
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
        check("code_err", 64'(bus.code_err), 64'(e.err));
`endif
        n_out++;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [NBITS*8-1:0] k, input logic c,
                      input logic [NBITS-1:0] es, input logic ec, input logic ee);
    set_op(k, c, es, ec, ee);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc) break;
    end
    check("accept_timeout", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_ab(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input logic c);
    logic [NBITS:0] r;
    r = {1'b0, a} + {1'b0, b} + (NBITS+1)'(c);
    send(to_kpg(a, b), c, r[NBITS-1:0], r[NBITS], 1'b0);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [NBITS*8-1:0] kv;
    logic [NBITS-1:0]   a, b;
    logic [NBITS:0]     r;
    logic               ci;
    logic               have;
    int                 idx;
    int                 last_acc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.kpg_in    = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    drv           = '{default: '0};
    repeat (3) @(negedge clk);

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef KPG_CARRY_PIPE_ERR_CHECK_EN
    check("rst_code_err", 64'(bus.code_err), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // All-propagate with cin=1 ripples through every slice; also measures latency.
    send(to_kpg(32'hFFFF_FFFF, 32'h0), 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    tick();
    tick();
    check("latency_3_not_yet", 64'(bus.out_valid), 64'd0);
    tick();
    check("latency_4_valid", 64'(bus.out_valid), 64'd1);
    drain();

    // Generate/kill patterns, back to back.
    send(to_kpg(32'h0000_00FF, 32'h0000_0001), 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    send(to_kpg(32'h8000_0000, 32'h8000_0000), 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send(to_kpg(32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    send(to_kpg(32'h00FF_0000, 32'h0001_0000), 1'b1, 32'h0100_0001, 1'b0, 1'b0);
    drain();

    // Byte 5 illegal, all others propagate, cin=1: bits 0..4 resolve to 0, bit 5 acts as kill
    // with carry 1 (sum 1), and bits 6..31 propagate carry 0 (sum 1).
    kv            = to_kpg(32'hFFFF_FFFF, 32'h0);
    kv[5*8 +: 8]  = 8'h00;
    send(kv, 1'b1, 32'hFFFF_FFE0, 1'b0, 1'b1);
    send_ab(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    drain();

    // Reset with three operations in flight: none of them may emerge.
    send_ab(32'h0000_0001, 32'h0000_0002, 1'b0);
    send_ab(32'h0000_0003, 32'h0000_0004, 1'b0);
    send_ab(32'h0000_0005, 32'h0000_0006, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum", 64'(bus.sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_idle", 64'(bus.out_valid), 64'd0);
    send_ab(32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    tick();
    tick();
    check("post_rst_latency_3", 64'(bus.out_valid), 64'd0);
    tick();
    check("post_rst_latency_4", 64'(bus.out_valid), 64'd1);
    drain();

    // Ten back-to-back operations with out_ready low for cycles 6..8.
    idx      = 0;
    n_out    = 0;
    have     = 1'b0;
    last_acc = -1;
    for (int c = 0; c < 60 && (idx < 10 || exp_q.size() != 0); c++) begin
      bus.out_ready = !(c >= 6 && c < 9);
      if (idx < 10) begin
        if (!have) begin
          a    = $urandom;
          b    = $urandom;
          ci   = 1'($urandom_range(1));
          have = 1'b1;
        end
        r = {1'b0, a} + {1'b0, b} + (NBITS+1)'(ci);
        set_op(to_kpg(a, b), ci, r[NBITS-1:0], r[NBITS], 1'b0);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 6 && c < 9) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      if (acc) begin
        idx++;
        have     = 1'b0;
        last_acc = c;
      end
    end
    bus.out_ready = 1'b1;
    check("tp_accepted", 64'(idx), 64'd10);
    check("tp_outputs", 64'(n_out), 64'd10);
    check("tp_last_accept_cycle", 64'(last_acc), 64'd12);
    drain();

    // Randomized regression with random valid and backpressure.
    idx   = 0;
    n_out = 0;
    for (int c = 0; c < 20000 && (idx < 2000 || exp_q.size() != 0); c++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      if (idx < 2000 && $urandom_range(7) != 0) begin
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(1));
        r  = {1'b0, a} + {1'b0, b} + (NBITS+1)'(ci);
        set_op(to_kpg(a, b), ci, r[NBITS-1:0], r[NBITS], 1'b0);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (acc) idx++;
    end
    bus.out_ready = 1'b1;
    check("rand_accepted", 64'(idx), 64'd2000);
    check("rand_outputs", 64'(n_out), 64'd2000);
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
